// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter that shares one left barrel shifter
//               (vacated LSBs filled with a per-request fill bit) among NREQ
//               valid/ready requesters. Each result is returned tagged with
//               the ID of the requester that issued it.
//               Optional per-requester grant counters are enabled by
//               defining SHIFT_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*N-1:0]             req_data,
    input  logic [NREQ*$clog2(N)-1:0]     req_amt,
    input  logic [NREQ-1:0]               req_shiftin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [N-1:0]                  rsp_data,
    output logic [$clog2(NREQ)-1:0]       rsp_id
`ifdef SHIFT_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]            grant_cnt
`endif
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_rr_ptr;
    logic [N-1:0]    r_data;
    logic [AW-1:0]   r_amt;
    logic            r_shiftin;
    logic [IW-1:0]   r_id;
    logic            r_rsp_valid;
    logic [N-1:0]    r_rsp_data;
    logic [IW-1:0]   r_rsp_id;

    logic            w_found;
    logic [IW-1:0]   w_grant;
    int              w_idx;
    logic            w_accept;
    logic [NREQ-1:0] w_ready;
    logic [N-1:0]    w_shift_out;
    logic [IW-1:0]   w_ptr_next;

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = IW'(w_idx);
            end
        end
    end

    // Pointer moves just past the winner so it cannot win twice in a row
    // while anyone else is waiting.
    assign w_ptr_next = (w_grant == IW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    // The single shifter instance, fed only by the captured operands.
    assign w_shift_out = (r_data << r_amt) |
                         (r_shiftin ? ~({N{1'b1}} << r_amt) : '0);

    // Next-state and handshake decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ready  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept         = 1'b1;
                    w_ready[w_grant] = 1'b1;
                    w_next           = S_SHIFT;
                end
            end
            S_SHIFT: w_next = S_HOLD;
            S_HOLD:  if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // req_ready must stay low while reset is held, even though the state
    // register already reads IDLE.
    assign req_ready = rst_n ? w_ready : '0;

    // State and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_rr_ptr <= w_ptr_next;
        end
    end

    // Capture the winning requester's operands on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_amt     <= '0;
            r_shiftin <= 1'b0;
            r_id      <= '0;
        end else if (w_accept) begin
            r_data    <= req_data[int'(w_grant)*N +: N];
            r_amt     <= req_amt[int'(w_grant)*AW +: AW];
            r_shiftin <= req_shiftin[w_grant];
            r_id      <= w_grant;
        end
    end

    // Response register: loaded in SHIFT, held through HOLD until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else if (r_state == S_SHIFT) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_shift_out;
            r_rsp_id    <= r_id;
        end else if (r_state == S_HOLD && r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef SHIFT_ARB_PERF_EN
    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_grant_cnt
            logic [15:0] r_cnt;
            // Saturating count of accepts for requester k.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_grant == IW'(k)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[k*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire
